famicom_pad_poller: RTL and testbench
=====================================

Name: famicom_pad_poller

Overview:
- Parametrised multi-channel Famicom/SNES serial pad reader for the Gigatron shell.
- Generates latch and pulse, and shifts in CHANNELS data lines of BITS bits each.
- Presents debounce-free, active-high button words with a one-cycle valid strobe.
- Supports a passthrough mode, so the core or loader can drive the pad bus directly, as it does today.

Parameters:
CHANNELS, 2, number of pads sharing latch/pulse, each with its own data line (1..4)
BITS, 8, bits shifted per pad (8 Famicom, 16 SNES)
LATCH_CYCLES, 600, clk cycles latch is held high (12 us at 50 MHz)
HALF_CYCLES, 300, clk cycles per pulse half-period; minimum 3
POLL_PERIOD, 0, auto-poll start-to-start interval in clk cycles; 0 disables auto-poll

Ports:
clk  in  1  system clock (50 MHz)
reset  in  1  synchronous, active-high reset
poll_req  in  1  one-cycle request to start a poll
passthrough  in  1  1 = hand the pad bus to core_latch/core_pulse/core_data
core_latch  in  1  latch from core/loader, used in passthrough
core_pulse  in  1  pulse from core/loader, used in passthrough
core_data  out  1  data to core: data_in[0] in passthrough, else 1
famicom_latch  out  1  latch to pads
famicom_pulse  out  1  pulse to pads
famicom_data  in  CHANNELS  raw active-low serial data, one bit per pad, asynchronous
buttons  out  CHANNELS*BITS  active-high button state; pad ch occupies [ch*BITS +: BITS]; bit 0 = first bit shifted
buttons_valid  out  1  one-cycle strobe when buttons update
busy  out  1  poll in progress
connected  out  CHANNELS  pad-present flags

Behaviour:
- Reset: all outputs go to 0 on the cycle after reset is sampled high: latch, pulse, buttons, buttons_valid, busy; mode = local; connected = all-ones without the optional feature, 0 with it.
- Reset mid-poll aborts the poll. Partial shift data is discarded.
- famicom_data passes through a 2-flop synchroniser before sampling.
- FSM states: IDLE, LATCH, SETTLE, PHI, PLO, DONE.
- IDLE: the mode register is loaded from passthrough only in this state.
  - If mode = local and a start occurs (poll_req, or auto tick): go to LATCH; busy = 1 from the next cycle.
- LATCH: famicom_latch = 1 for LATCH_CYCLES cycles, then SETTLE.
- SETTLE: latch = 0 for HALF_CYCLES cycles. On the last cycle, sample bit 0 of every channel. Then go to PHI, or to DONE if BITS = 1.
- PHI/PLO: pulse = 1 for HALF_CYCLES cycles, then 0 for HALF_CYCLES cycles. Sample the next bit on the last PLO cycle. Repeat until BITS bits are sampled.
- DONE: one cycle.
  - buttons <= ~shifted data.
  - buttons_valid = 1, busy drops.
  - Return to IDLE.
- Latency: buttons_valid asserts exactly LATCH_CYCLES + (2*BITS-1)*HALF_CYCLES + 1 cycles after poll_req is sampled.
- latch and pulse are registered in local mode. buttons holds its value between polls.
- poll_req while busy, or while mode = passthrough, is ignored (not queued).
- Passthrough (mode = 1, IDLE only): combinational mux.
  - famicom_latch = core_latch, famicom_pulse = core_pulse, core_data = famicom_data[0] (raw, unsynchronised).
  - No polls run in this mode.
- Mode changes:
  - passthrough asserted mid-poll: the poll completes and the switch takes effect in IDLE the next cycle.
  - passthrough deasserted: local mode with latch = pulse = 0 the next cycle.
- Auto-poll (POLL_PERIOD > 0):
  - A free-running counter of width clog2(POLL_PERIOD) wraps every POLL_PERIOD cycles and emits a tick.
  - A tick while busy or in passthrough is dropped.
  - The counter resets to 0 on reset.
  - A poll_req coinciding with a tick starts one poll only.

Optional Feature:
- FAMICOM_CONNECT_DETECT_EN defined:
  - After bit BITS-1, one extra PHI/PLO pair is generated and an extra bit is sampled.
  - A 4021 shifts in ground, so extra = 0 means the pad is present: connected[ch] = ~extra[ch].
  - buttons for a channel with connected = 0 are forced to 0.
  - Latency grows by 2*HALF_CYCLES.
- Undefined: no extra pulse; connected is constant all-ones.

Test Plan:
1. Basic poll. CHANNELS=2, BITS=8, LATCH=4, HALF=3. Pad models return active-low 8'hA5 (ch0) and 8'h3C (ch1), bit 0 first. Pulse poll_req → latch high 4 cycles, 7 pulses 3 high/3 low, buttons_valid exactly 50 cycles after poll_req, buttons = 16'hC35A, busy low the cycle after.
2. Request while busy. poll_req again at cycle 10 of a poll → ignored; exactly one buttons_valid; a poll_req one cycle after valid starts a new poll.
3. Passthrough.
   - passthrough = 1 in IDLE: famicom_latch/pulse track core_latch/core_pulse the same cycle; core_data follows famicom_data[0]; poll_req gives no busy.
   - passthrough asserted at cycle 20 of a poll: valid still at cycle 50, mux switches on cycle 51.
4. Auto-poll. POLL_PERIOD=100, no poll_req → buttons_valid at 100-cycle spacing over 5 periods; a poll_req on a tick cycle → a single poll.
5. Reset mid-poll. reset at cycle 20 of a poll → next cycle latch = pulse = busy = buttons_valid = 0, buttons = 0; a following poll returns correct data at 50-cycle latency.
6. Connect detect (FAMICOM_CONNECT_DETECT_EN). ch1 data held 1 (unplugged), ch0 a real pad shifting 0 after 8 bits → connected = 2'b01, buttons[15:8] = 0, valid at cycle 56.

Source files
------------

// File: rtl/famicom_pad_poller.sv
// Multi-channel Famicom/SNES serial pad reader with a raw passthrough path for the core/loader.
// Optional: define FAMICOM_CONNECT_DETECT_EN to clock one extra bit per poll for pad-present flags.
module famicom_pad_poller #(
    parameter int unsigned CHANNELS     = 2,
    parameter int unsigned BITS         = 8,
    parameter int unsigned LATCH_CYCLES = 600,
    parameter int unsigned HALF_CYCLES  = 300,
    parameter int unsigned POLL_PERIOD  = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     poll_req,
    input  logic                     passthrough,
    input  logic                     core_latch,
    input  logic                     core_pulse,
    output logic                     core_data,
    output logic                     famicom_latch,
    output logic                     famicom_pulse,
    input  logic [CHANNELS-1:0]      famicom_data,
    output logic [CHANNELS*BITS-1:0] buttons,
    output logic                     buttons_valid,
    output logic                     busy,
    output logic [CHANNELS-1:0]      connected
);

`ifdef FAMICOM_CONNECT_DETECT_EN
    localparam bit          DetectEn   = 1'b1;
    localparam int unsigned NumSamples = BITS + 1;
`else
    localparam bit          DetectEn   = 1'b0;
    localparam int unsigned NumSamples = BITS;
`endif
    localparam int unsigned MaxCount = (LATCH_CYCLES > HALF_CYCLES) ? LATCH_CYCLES : HALF_CYCLES;
    localparam int unsigned CntW     = (MaxCount > 1) ? $clog2(MaxCount) : 1;
    localparam int unsigned BitW     = (NumSamples > 1) ? $clog2(NumSamples) : 1;
    localparam int unsigned IdxW     = (BITS > 1) ? $clog2(BITS) : 1;

    localparam logic [CntW-1:0] LatchLast  = CntW'(LATCH_CYCLES - 1);
    localparam logic [CntW-1:0] HalfLast   = CntW'(HALF_CYCLES - 1);
    localparam logic [BitW-1:0] SampleLast = BitW'(NumSamples - 1);

    typedef enum logic [2:0] {StIdle, StLatch, StSettle, StPhi, StPlo, StDone} state_e;

    state_e                    state_q, state_d;
    logic [CntW-1:0]           cnt_q, cnt_d;
    logic [BitW-1:0]           bit_cnt_q, bit_cnt_d;
    logic                      mode_q, latch_q, pulse_q, valid_q;
    logic [CHANNELS-1:0]       sync1_q, sync_q;
    logic [BITS-1:0]           shift_q [CHANNELS];
    logic [CHANNELS*BITS-1:0]  buttons_q;
    logic [CHANNELS-1:0]       present;
    logic                      tick, start, sample, last_sample, data_sample, pass_active;

    generate
        if (POLL_PERIOD > 0) begin : g_auto
            localparam int unsigned TW = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
            localparam logic [TW-1:0] TickLast = TW'(POLL_PERIOD - 1);
            logic [TW-1:0] tick_cnt_q;

            always_ff @(posedge clk) begin
                if (reset || tick_cnt_q == TickLast) tick_cnt_q <= '0;
                else                                 tick_cnt_q <= tick_cnt_q + TW'(1);
            end
            assign tick = (tick_cnt_q == TickLast);
        end else begin : g_no_auto
            assign tick = 1'b0;
        end
    endgenerate

    assign start       = !mode_q && (poll_req || tick);
    assign last_sample = (bit_cnt_q == SampleLast);
    // The connect-detect bit lands in its own register, not in the button word.
    assign data_sample = sample && !(DetectEn && last_sample);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_cnt_d = bit_cnt_q;
        sample    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d   = StLatch;
                    cnt_d     = '0;
                    bit_cnt_d = '0;
                end
            end
            StLatch: begin
                if (cnt_q == LatchLast) begin
                    state_d = StSettle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StSettle, StPlo: begin
                if (cnt_q == HalfLast) begin
                    cnt_d  = '0;
                    sample = 1'b1;
                    if (last_sample) begin
                        state_d = StDone;
                    end else begin
                        state_d   = StPhi;
                        bit_cnt_d = bit_cnt_q + BitW'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StPhi: begin
                if (cnt_q == HalfLast) begin
                    state_d = StPlo;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            mode_q    <= 1'b0;
            latch_q   <= 1'b0;
            pulse_q   <= 1'b0;
            valid_q   <= 1'b0;
            sync1_q   <= '1;
            sync_q    <= '1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            latch_q   <= (state_d == StLatch);
            pulse_q   <= (state_d == StPhi);
            valid_q   <= (state_q == StDone);
            sync1_q   <= famicom_data;
            sync_q    <= sync1_q;
            // Mode only follows passthrough while the bus is quiet.
            if (state_q == StIdle && state_d == StIdle) mode_q <= passthrough;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int ch = 0; ch < CHANNELS; ch++) shift_q[ch] <= '0;
        end else if (data_sample) begin
            for (int ch = 0; ch < CHANNELS; ch++) shift_q[ch][bit_cnt_q[IdxW-1:0]] <= sync_q[ch];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            buttons_q <= '0;
        end else if (state_q == StDone) begin
            for (int ch = 0; ch < CHANNELS; ch++) begin
                buttons_q[ch*BITS +: BITS] <= present[ch] ? ~shift_q[ch] : '0;
            end
        end
    end

`ifdef FAMICOM_CONNECT_DETECT_EN
    logic [CHANNELS-1:0] extra_q, connected_q;

    // A plugged-in 4021 shifts in ground after its last button bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            extra_q     <= '0;
            connected_q <= '0;
        end else begin
            if (sample && last_sample) extra_q <= sync_q;
            if (state_q == StDone) connected_q <= ~extra_q;
        end
    end
    assign present   = ~extra_q;
    assign connected = connected_q;
`else
    assign present   = '1;
    assign connected = '1;
`endif

    assign pass_active   = mode_q && (state_q == StIdle);
    assign famicom_latch = pass_active ? core_latch : latch_q;
    assign famicom_pulse = pass_active ? core_pulse : pulse_q;
    assign core_data     = pass_active ? famicom_data[0] : 1'b1;
    assign buttons       = buttons_q;
    assign buttons_valid = valid_q;
    assign busy          = (state_q != StIdle);

endmodule

// File: tb/tb_famicom_pad_poller.sv
// Randomized bench for famicom_pad_poller: 4021-style pad models, expected words and timing
// derived from the protocol rules; a second instance covers auto-poll.
module tb_famicom_pad_poller;
    localparam int Ch = 2, Bits = 8, Latch = 4, Half = 3, Period = 100;
`ifdef FAMICOM_CONNECT_DETECT_EN
    localparam int Det = 1;
`else
    localparam int Det = 0;
`endif
    localparam int ExpLat = Latch + (2 * Bits - 1 + 2 * Det) * Half + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, poll_req, passthrough, core_latch, core_pulse, core_data, fl, fp, valid, busy;
    logic [Ch-1:0] fd, connected;
    logic [Ch*Bits-1:0] buttons;
    logic reset_b, poll_req_b, core_data_b, fl_b, fp_b, valid_b, busy_b;
    logic [Ch-1:0] fd_b, connected_b;
    logic [Ch*Bits-1:0] buttons_b;

    famicom_pad_poller #(.CHANNELS(Ch), .BITS(Bits), .LATCH_CYCLES(Latch),
                         .HALF_CYCLES(Half), .POLL_PERIOD(0)) dut (
        .clk(clk), .reset(reset), .poll_req(poll_req), .passthrough(passthrough),
        .core_latch(core_latch), .core_pulse(core_pulse), .core_data(core_data),
        .famicom_latch(fl), .famicom_pulse(fp), .famicom_data(fd), .buttons(buttons),
        .buttons_valid(valid), .busy(busy), .connected(connected));

    famicom_pad_poller #(.CHANNELS(Ch), .BITS(Bits), .LATCH_CYCLES(Latch),
                         .HALF_CYCLES(Half), .POLL_PERIOD(Period)) dut_auto (
        .clk(clk), .reset(reset_b), .poll_req(poll_req_b), .passthrough(1'b0),
        .core_latch(1'b0), .core_pulse(1'b0), .core_data(core_data_b),
        .famicom_latch(fl_b), .famicom_pulse(fp_b), .famicom_data(fd_b), .buttons(buttons_b),
        .buttons_valid(valid_b), .busy(busy_b), .connected(connected_b));

    // Pad model: latch reloads, each pulse rising edge advances one bit, then ground shifts out.
    logic [Bits-1:0] pad_press [Ch];
    logic [Ch-1:0]   pad_present;
    int idx_a = 0, idx_b = 0;

    always @(posedge fl or posedge fp) idx_a = fl ? 0 : idx_a + 1;
    always @(posedge fl_b or posedge fp_b) idx_b = fl_b ? 0 : idx_b + 1;

    function automatic logic pad_bit(input logic present, input logic [Bits-1:0] press,
                                     input int idx);
        if (!present) return 1'b1;
        if (idx < Bits) return ~press[idx];
        return 1'b0;
    endfunction

    always_comb begin
        for (int ch = 0; ch < Ch; ch++) begin
            fd[ch]   = pad_bit(pad_present[ch], pad_press[ch], idx_a);
            fd_b[ch] = pad_bit(pad_present[ch], pad_press[ch], idx_b);
        end
    end

    function automatic logic [Ch*Bits-1:0] exp_buttons();
        logic [Ch*Bits-1:0] r;
        for (int ch = 0; ch < Ch; ch++) r[ch*Bits +: Bits] = pad_present[ch] ? pad_press[ch] : '0;
        return r;
    endfunction

    function automatic logic [Ch-1:0] exp_conn();
        return (Det != 0) ? pad_present : '1;
    endfunction

    int n_total = 0, n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic randomize_pads(input bool_unplug);
        pad_press[0] = 8'($urandom);
        pad_press[1] = 8'($urandom);
        pad_present  = (bool_unplug && $urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b11;
    endtask

    // Starts a poll at the current negedge; optional extra request / passthrough mid-poll.
    task automatic poll_once(input int inj_at, input int pass_at);
        int lat, latch_hi, pulses;
        logic prev_p;
        logic [Ch*Bits-1:0] eb;
        logic [Ch-1:0] ec;
        lat = -1; latch_hi = 0; pulses = 0; prev_p = 1'b0;
        eb = exp_buttons();
        ec = exp_conn();
        poll_req = 1'b1;
        for (int k = 1; k <= ExpLat + 40; k++) begin
            @(negedge clk);
            poll_req = 1'b0;
            if (k == 1) check_eq("busy_start", busy, 1);
            if (fl) latch_hi++;
            if (fp && !prev_p) pulses++;
            prev_p = fp;
            if (valid) begin
                lat = k - 1;
                break;
            end
            if (k == inj_at) poll_req = 1'b1;
            if (k == pass_at) begin
                passthrough = 1'b1;
                core_latch  = 1'b1;
                core_pulse  = 1'b1;
            end
        end
        check_eq("latency", lat, ExpLat);
        check_eq("latch_len", latch_hi, Latch);
        check_eq("pulses", pulses, Bits - 1 + Det);
        check_eq("buttons", buttons, eb);
        check_eq("connected", connected, ec);
        check_eq("busy_end", busy, 0);
        if (pass_at > 0) begin
            check_eq("pass_not_yet", {fl, fp}, 2'b00);
            @(negedge clk);
            check_eq("pass_switch", {fl, fp}, 2'b11);
            passthrough = 1'b0;
            core_latch  = 1'b0;
            core_pulse  = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic auto_test();
        int cyc, vl, target, n, vc;
        int vq[$];
        @(negedge clk);
        reset_b = 1'b0;
        cyc = 0;
        while (cyc < 560) begin
            @(negedge clk);
            cyc++;
            if (valid_b) vq.push_back(cyc);
        end
        check_eq("auto_count", vq.size(), 5);
        check_eq("auto_first", (vq.size() > 0) ? vq[0] : -1, Period + ExpLat);
        for (int i = 1; i < vq.size(); i++) check_eq("auto_spacing", vq[i] - vq[i-1], Period);
        check_eq("auto_buttons", buttons_b, exp_buttons());
        vl = (vq.size() > 0) ? vq[vq.size()-1] : 4 * Period + Period + ExpLat;
        target = vl - ExpLat + Period;
        n = 0; vc = -1;
        while (cyc < target + Period - 1) begin
            @(negedge clk);
            cyc++;
            poll_req_b = 1'b0;
            if (valid_b) begin
                n++;
                vc = cyc;
            end
            if (cyc == target - 1) poll_req_b = 1'b1;
        end
        check_eq("auto_coincide_count", n, 1);
        check_eq("auto_coincide_time", vc, target + ExpLat);
    endtask

    initial begin
        logic bsy;
        reset = 1'b1; poll_req = 1'b0; passthrough = 1'b0; core_latch = 1'b0; core_pulse = 1'b0;
        reset_b = 1'b1; poll_req_b = 1'b0;
        pad_press[0] = 8'h5A; pad_press[1] = 8'hC3; pad_present = 2'b11;
        repeat (3) @(negedge clk);
        check_eq("rst_ctrl", {fl, fp, busy, valid}, 0);
        check_eq("rst_buttons", buttons, 0);
        check_eq("rst_connected", connected, (Det != 0) ? 0 : 3);
        check_eq("rst_core_data", core_data, 1);
        reset = 1'b0;
        @(negedge clk);

        poll_once(0, 0);
        randomize_pads(1'b0);
        poll_once(10, 0);
        randomize_pads(1'b0);
        poll_once(0, 0);
        for (int i = 0; i < 6; i++) begin
            randomize_pads(1'b1);
            poll_once($urandom_range(2, 40), 0);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        pad_press[0] = 8'($urandom);
        pad_present  = 2'b01;
        poll_once(0, 0);
        pad_present = 2'b11;

        passthrough = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            core_latch   = 1'($urandom);
            core_pulse   = 1'($urandom);
            pad_present  = {1'b1, 1'($urandom)};
            pad_press[0] = 8'($urandom);
            #1;
            check_eq("pass_latch", fl, core_latch);
            check_eq("pass_pulse", fp, core_pulse);
            check_eq("pass_data", core_data, fd[0]);
            @(negedge clk);
        end
        poll_req = 1'b1;
        bsy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            poll_req = 1'b0;
            bsy = bsy | busy;
        end
        check_eq("pass_no_poll", bsy, 0);
        core_latch = 1'b1; core_pulse = 1'b1; passthrough = 1'b0;
        @(negedge clk);
        check_eq("pass_exit", {fl, fp, core_data}, 3'b001);
        core_latch = 1'b0; core_pulse = 1'b0; pad_present = 2'b11;

        randomize_pads(1'b0);
        poll_once(0, 20);

        poll_req = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            poll_req = 1'b0;
        end
        check_eq("midrst_busy", busy, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_eq("midrst_ctrl", {fl, fp, busy, valid}, 0);
        check_eq("midrst_buttons", buttons, 0);
        randomize_pads(1'b0);
        poll_once(0, 0);

        randomize_pads(1'b0);
        auto_test();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
